// File: rtl/beezip_lane_dispatch.sv
// Spreads delimited input blocks round-robin over the enabled compressor lanes.
// Lane sequence outputs are merged back into the original block order.
module beezip_lane_dispatch #(
    parameter int LANE_NUM    = 4,
    parameter int DATA_W      = 256,
    parameter int SEQ_W       = 256,
    parameter int ORDER_DEPTH = 8,
    localparam int CNT_W      = $clog2(ORDER_DEPTH + 1)
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [LANE_NUM-1:0]       cfg_lane_mask,
    input  logic                      input_valid,
    output logic                      input_ready,
    input  logic                      input_delim,
    input  logic [DATA_W-1:0]         input_data,
    output logic [LANE_NUM-1:0]       lane_in_valid,
    input  logic [LANE_NUM-1:0]       lane_in_ready,
    output logic                      lane_in_delim,
    output logic [DATA_W-1:0]         lane_in_data,
    input  logic [LANE_NUM-1:0]       lane_out_valid,
    input  logic [LANE_NUM-1:0]       lane_out_last,
    input  logic [LANE_NUM*SEQ_W-1:0] lane_out_seq_quad,
    output logic [LANE_NUM-1:0]       lane_out_ready,
    output logic                      output_valid,
    output logic                      output_last,
    output logic [SEQ_W-1:0]          output_seq_quad,
    input  logic                      output_ready,
    output logic [CNT_W-1:0]          blocks_in_flight
);
    localparam int LANE_W = $clog2(LANE_NUM);
    localparam int PTR_W  = $clog2(ORDER_DEPTH);

    logic [LANE_W-1:0]   ptr_reg, cur_reg, sel, scan_sel, ptr_next, head;
    logic                in_block_reg;
    logic [LANE_NUM-1:0] eff_mask;
    logic                go, accept, push, pop, load, out_accept;
    logic                fifo_full, fifo_nonempty;

    logic [LANE_W-1:0]   order_mem [ORDER_DEPTH];
    logic [PTR_W-1:0]    wr_ptr_reg, rd_ptr_reg;
    logic [CNT_W-1:0]    count_reg;

    logic                output_valid_reg, output_last_reg;
    logic [SEQ_W-1:0]    output_seq_quad_reg;
    logic [SEQ_W-1:0]    lane_quad [LANE_NUM];

    // An empty mask would leave nowhere to send data, so it falls back to lane 0.
    assign eff_mask = (cfg_lane_mask == '0) ? LANE_NUM'(1) : cfg_lane_mask;

    always_comb begin
        logic found;
        scan_sel = ptr_reg;
        found    = 1'b0;
        for (int k = 0; k < LANE_NUM; k++) begin
            int idx;
            idx = int'(ptr_reg) + k;
            if (idx >= LANE_NUM) idx = idx - LANE_NUM;
            if (!found && eff_mask[idx]) begin
                scan_sel = LANE_W'(idx);
                found    = 1'b1;
            end
        end
    end

    assign sel      = in_block_reg ? cur_reg : scan_sel;
    assign ptr_next = (sel == LANE_W'(LANE_NUM - 1)) ? '0 : sel + LANE_W'(1);

    assign fifo_full     = (count_reg == CNT_W'(ORDER_DEPTH));
    assign fifo_nonempty = (count_reg != '0);
    assign go            = in_block_reg | ~fifo_full;
    assign input_ready   = lane_in_ready[sel] & go;
    assign accept        = input_valid & input_ready;
    assign push          = accept & ~in_block_reg;
    assign lane_in_delim = input_delim;
    assign lane_in_data  = input_data;

    assign head       = order_mem[rd_ptr_reg];
    assign out_accept = ~output_valid_reg | output_ready;
    assign load       = fifo_nonempty & lane_out_valid[head] & out_accept;
    assign pop        = load & lane_out_last[head];

    genvar gi;
    generate
        for (gi = 0; gi < LANE_NUM; gi++) begin : g_lane
            assign lane_in_valid[gi]  = input_valid & go & (sel == LANE_W'(gi));
            assign lane_out_ready[gi] = fifo_nonempty & out_accept & (head == LANE_W'(gi));
            assign lane_quad[gi]      = lane_out_seq_quad[gi*SEQ_W +: SEQ_W];
        end
    endgenerate

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            ptr_reg      <= '0;
            cur_reg      <= '0;
            in_block_reg <= 1'b0;
        end else if (accept) begin
            if (!in_block_reg) cur_reg <= sel;
            if (input_delim) begin
                in_block_reg <= 1'b0;
                ptr_reg      <= ptr_next;
            end else begin
                in_block_reg <= 1'b1;
            end
        end
    end

    // Order storage needs no reset; only the pointers define its contents.
    always_ff @(posedge clk) begin
        if (push) order_mem[wr_ptr_reg] <= sel;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (push) wr_ptr_reg <= wr_ptr_reg + PTR_W'(1);
            if (pop)  rd_ptr_reg <= rd_ptr_reg + PTR_W'(1);
            if (push && !pop)      count_reg <= count_reg + CNT_W'(1);
            else if (pop && !push) count_reg <= count_reg - CNT_W'(1);
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            output_valid_reg    <= 1'b0;
            output_last_reg     <= 1'b0;
            output_seq_quad_reg <= '0;
        end else if (load) begin
            output_valid_reg    <= 1'b1;
            output_last_reg     <= lane_out_last[head];
            output_seq_quad_reg <= lane_quad[head];
        end else if (output_ready) begin
            output_valid_reg <= 1'b0;
        end
    end

    assign output_valid     = output_valid_reg;
    assign output_last      = output_last_reg;
    assign output_seq_quad  = output_seq_quad_reg;
    assign blocks_in_flight = count_reg;
endmodule

// File: tb/tb_beezip_lane_dispatch.sv
// Directed bench for beezip_lane_dispatch: dispatch order, mask handling,
// order-FIFO full behaviour and in-order merging of lane outputs.
module tb_beezip_lane_dispatch;
    localparam int LN = 4;
    localparam int DW = 256;
    localparam int SW = 256;
    localparam int OD = 8;
    localparam int CW = $clog2(OD + 1);

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic [LN-1:0]     cfg_lane_mask = '1;
    logic              input_valid = 1'b0;
    logic              input_ready;
    logic              input_delim = 1'b0;
    logic [DW-1:0]     input_data = '0;
    logic [LN-1:0]     lane_in_valid;
    logic [LN-1:0]     lane_in_ready = '1;
    logic              lane_in_delim;
    logic [DW-1:0]     lane_in_data;
    logic [LN-1:0]     lane_out_valid;
    logic [LN-1:0]     lane_out_last;
    logic [LN*SW-1:0]  lane_out_seq_quad;
    logic [LN-1:0]     lane_out_ready;
    logic              output_valid;
    logic              output_last;
    logic [SW-1:0]     output_seq_quad;
    logic              output_ready;
    logic [CW-1:0]     blocks_in_flight;

    always #5 clk = ~clk;

    beezip_lane_dispatch #(.LANE_NUM(LN), .DATA_W(DW), .SEQ_W(SW), .ORDER_DEPTH(OD)) dut (
        .clk(clk), .rst(rst), .cfg_lane_mask(cfg_lane_mask),
        .input_valid(input_valid), .input_ready(input_ready),
        .input_delim(input_delim), .input_data(input_data),
        .lane_in_valid(lane_in_valid), .lane_in_ready(lane_in_ready),
        .lane_in_delim(lane_in_delim), .lane_in_data(lane_in_data),
        .lane_out_valid(lane_out_valid), .lane_out_last(lane_out_last),
        .lane_out_seq_quad(lane_out_seq_quad), .lane_out_ready(lane_out_ready),
        .output_valid(output_valid), .output_last(output_last),
        .output_seq_quad(output_seq_quad), .output_ready(output_ready),
        .blocks_in_flight(blocks_in_flight)
    );

    int checks_total  = 0;
    int checks_passed = 0;

    logic [SW:0] lane_q [LN][$];
    logic [SW:0] got_q [$];
    logic [SW:0] exp_q [$];
    logic [LN-1:0] take;
    bit rand_bp = 1'b0;

    task automatic check(input string tag, input logic [263:0] got, input logic [263:0] exp);
        checks_total++;
        if (got === exp) begin
            checks_passed++;
            $display("ok   %s = %0h", tag, got);
        end else begin
            $display("FAIL %s got %0h exp %0h", tag, got, exp);
        end
    endtask

    // Lane output model and merged-output monitor.
    initial begin
        lane_out_valid    = '0;
        lane_out_last     = '0;
        lane_out_seq_quad = '0;
        output_ready      = 1'b1;
        forever begin
            @(negedge clk);
            for (int i = 0; i < LN; i++) take[i] = lane_out_valid[i] & lane_out_ready[i];
            if (output_valid && output_ready) got_q.push_back({output_last, output_seq_quad});
            @(posedge clk);
            #2;
            for (int i = 0; i < LN; i++) begin
                if (take[i] && lane_q[i].size() > 0) void'(lane_q[i].pop_front());
                if (lane_q[i].size() > 0) begin
                    lane_out_valid[i]            = 1'b1;
                    lane_out_last[i]             = lane_q[i][0][SW];
                    lane_out_seq_quad[i*SW +: SW] = lane_q[i][0][SW-1:0];
                end else begin
                    lane_out_valid[i]            = 1'b0;
                    lane_out_last[i]             = 1'b0;
                    lane_out_seq_quad[i*SW +: SW] = '0;
                end
            end
            output_ready = rand_bp ? 1'($urandom_range(0, 1)) : 1'b1;
        end
    end

    task automatic do_reset();
        rst = 1'b1;
        input_valid = 1'b0;
        input_delim = 1'b0;
        @(posedge clk); #1;
        for (int i = 0; i < LN; i++) lane_q[i].delete();
        got_q.delete();
        exp_q.delete();
        @(posedge clk); #1;
        rst = 1'b0;
    endtask

    // Called at posedge+1; returns at posedge+1 after the beat is accepted.
    task automatic send_beat(input string tag, input logic delim, input logic [LN-1:0] exp_onehot);
        int n = 0;
        input_valid = 1'b1;
        input_delim = delim;
        input_data  = DW'($urandom);
        @(negedge clk);
        while (!input_ready && n < 100) begin
            @(posedge clk);
            @(negedge clk);
            n++;
        end
        if (!input_ready) check({tag, "_timeout"}, 264'd0, 264'd1);
        check(tag, 264'(lane_in_valid), 264'(exp_onehot));
        @(posedge clk); #1;
        input_valid = 1'b0;
        input_delim = 1'b0;
    endtask

    initial begin
        int lane_idx [6] = '{0, 1, 3, 0, 1, 3};
        int beats    [6] = '{1, 2, 3, 1, 2, 3};
        int quads    [6] = '{2, 1, 3, 3, 1, 2};
        int n;

        // Reset state
        do_reset();
        @(negedge clk);
        check("rst_out_valid", 264'(output_valid), 264'd0);
        check("rst_out_last", 264'(output_last), 264'd0);
        check("rst_out_quad", 264'(output_seq_quad), 264'd0);
        check("rst_in_flight", 264'(blocks_in_flight), 264'd0);
        check("rst_lane_in_valid", 264'(lane_in_valid), 264'd0);
        check("rst_lane_out_ready", 264'(lane_out_ready), 264'd0);
        @(posedge clk); #1;

        // Four two-beat blocks over all lanes
        cfg_lane_mask = 4'b1111;
        for (int b = 0; b < 4; b++) begin
            send_beat($sformatf("t1_b%0d_beat0", b), 1'b0, 4'(1 << b));
            send_beat($sformatf("t1_b%0d_beat1", b), 1'b1, 4'(1 << b));
        end
        @(negedge clk);
        check("t1_in_flight", 264'(blocks_in_flight), 264'd4);
        @(posedge clk); #1;
        send_beat("t1_ptr_wrap", 1'b1, 4'b0001);

        // Sparse mask, single-beat blocks
        do_reset();
        cfg_lane_mask = 4'b1010;
        send_beat("t2_b0", 1'b1, 4'b0010);
        send_beat("t2_b1", 1'b1, 4'b1000);
        send_beat("t2_b2", 1'b1, 4'b0010);
        @(negedge clk);
        check("t2_in_flight", 264'(blocks_in_flight), 264'd3);
        @(posedge clk); #1;

        // Empty mask falls back to lane 0
        do_reset();
        cfg_lane_mask = 4'b0000;
        send_beat("t3_b0", 1'b1, 4'b0001);
        send_beat("t3_b1", 1'b1, 4'b0001);
        send_beat("t3_b2_beat0", 1'b0, 4'b0001);
        send_beat("t3_b2_beat1", 1'b1, 4'b0001);

        // Mask change mid-block
        do_reset();
        cfg_lane_mask = 4'b1111;
        send_beat("t4_b0", 1'b1, 4'b0001);
        send_beat("t4_b1", 1'b1, 4'b0010);
        send_beat("t4_b2_beat0", 1'b0, 4'b0100);
        cfg_lane_mask = 4'b0001;
        send_beat("t4_b2_beat1", 1'b0, 4'b0100);
        send_beat("t4_b2_beat2", 1'b1, 4'b0100);
        send_beat("t4_b3", 1'b1, 4'b0001);

        // Order FIFO full, released by one pop
        do_reset();
        cfg_lane_mask = 4'b1111;
        for (int b = 0; b < 8; b++) send_beat($sformatf("t5_b%0d", b), 1'b1, 4'(1 << (b % 4)));
        @(negedge clk);
        check("t5_in_flight_full", 264'(blocks_in_flight), 264'd8);
        @(posedge clk); #1;
        input_valid = 1'b1;
        input_delim = 1'b1;
        lane_q[0].push_back({1'b1, 256'hC0FFEE});
        @(negedge clk);
        check("t5_full_ready", 264'(input_ready), 264'd0);
        check("t5_full_lane_valid", 264'(lane_in_valid), 264'd0);
        @(posedge clk); #1;
        @(negedge clk);
        check("t5_after_pop_ready", 264'(input_ready), 264'd1);
        check("t5_after_pop_lane", 264'(lane_in_valid), 264'b0001);
        check("t5_out_valid", 264'(output_valid), 264'd1);
        check("t5_out_quad", 264'(output_seq_quad), 264'hC0FFEE);
        check("t5_out_last", 264'(output_last), 264'd1);
        check("t5_in_flight_pop", 264'(blocks_in_flight), 264'd7);
        @(posedge clk); #1;
        input_valid = 1'b0;
        input_delim = 1'b0;
        @(negedge clk);
        check("t5_in_flight_refill", 264'(blocks_in_flight), 264'd8);
        @(posedge clk); #1;

        // Lane 1 finishes before lane 0
        do_reset();
        cfg_lane_mask = 4'b1111;
        send_beat("t6_b0", 1'b1, 4'b0001);
        send_beat("t6_b1", 1'b1, 4'b0010);
        for (int q = 0; q < 3; q++) lane_q[1].push_back({(q == 2), SW'(32'hB0 + q)});
        repeat (4) @(posedge clk);
        @(negedge clk);
        check("t6_stall_valid", 264'(output_valid), 264'd0);
        check("t6_stall_ready", 264'(lane_out_ready), 264'b0001);
        @(posedge clk); #1;
        for (int q = 0; q < 3; q++) lane_q[0].push_back({(q == 2), SW'(32'hA0 + q)});
        for (int q = 0; q < 3; q++) exp_q.push_back({(q == 2), SW'(32'hA0 + q)});
        for (int q = 0; q < 3; q++) exp_q.push_back({(q == 2), SW'(32'hB0 + q)});
        n = 0;
        while (got_q.size() < 6 && n < 100) begin @(posedge clk); n++; end
        #1;
        check("t6_count", 264'(got_q.size()), 264'd6);
        for (int k = 0; k < 6 && k < got_q.size(); k++)
            check($sformatf("t6_out%0d", k + 1), 264'(got_q[k]), 264'(exp_q[k]));
        @(negedge clk);
        check("t6_in_flight", 264'(blocks_in_flight), 264'd0);
        @(posedge clk); #1;

        // Random output backpressure, mask skipping lane 2
        do_reset();
        cfg_lane_mask = 4'b1011;
        rand_bp = 1'b1;
        for (int b = 0; b < 6; b++) begin
            for (int q = 0; q < quads[b]; q++) begin
                logic [SW:0] e;
                e = {(q == quads[b] - 1), SW'(32'h7000 + b * 16 + q)};
                lane_q[lane_idx[b]].push_back(e);
                exp_q.push_back(e);
            end
            for (int j = 0; j < beats[b]; j++)
                send_beat($sformatf("t7_b%0d_beat%0d", b, j), (j == beats[b] - 1),
                          4'(1 << lane_idx[b]));
        end
        n = 0;
        while (got_q.size() < exp_q.size() && n < 2000) begin @(posedge clk); n++; end
        repeat (5) @(posedge clk);
        #1;
        check("t7_count", 264'(got_q.size()), 264'(exp_q.size()));
        for (int k = 0; k < exp_q.size() && k < got_q.size(); k++)
            check($sformatf("t7_out%0d", k), 264'(got_q[k]), 264'(exp_q[k]));
        check("t7_in_flight", 264'(blocks_in_flight), 264'd0);
        rand_bp = 1'b0;

        $display("%0d/%0d checks passed", checks_passed, checks_total);
        $finish;
    end
endmodule

// File: doc/beezip_lane_dispatch.md
Name: beezip_lane_dispatch

Overview:
- Scales compression throughput by spreading delimited input blocks across LANE_NUM independent compressor lanes, each a hash engine plus match engine pair.
- Dispatches whole blocks round-robin over the enabled lanes.
- Records the dispatch order and re-serialises the lanes' sequence outputs in that order, so the downstream sequence stream matches the input block order.
- Sits between the top-level input/output handshake and the lane array.

Parameters:
LANE_NUM, 4, number of compressor lanes (2..8)
DATA_W, 256, input beat width in bits (HASH_ISSUE_WIDTH*8)
SEQ_W, 256, sequence quad width in bits (64*4)
ORDER_DEPTH, 8, order FIFO entries, i.e. max blocks in flight (power of 2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
cfg_lane_mask  in  LANE_NUM  lane enable bits; all-zero is treated as lane 0 only
input_valid  in  1  input beat valid
input_ready  out  1  input beat accepted when valid&ready
input_delim  in  1  beat is the last beat of its block
input_data  in  DATA_W  input bytes
lane_in_valid  out  LANE_NUM  per-lane beat valid
lane_in_ready  in  LANE_NUM  per-lane beat ready
lane_in_delim  out  1  broadcast delim
lane_in_data  out  DATA_W  broadcast data
lane_out_valid  in  LANE_NUM  per-lane sequence valid
lane_out_last  in  LANE_NUM  quad is the last of that lane's block
lane_out_seq_quad  in  LANE_NUM*SEQ_W  per-lane sequence quads, lane i at bits [i*SEQ_W +: SEQ_W]
lane_out_ready  out  LANE_NUM  per-lane sequence ready
output_valid  out  1  merged sequence valid (registered)
output_last  out  1  merged quad is the last of its block (registered)
output_seq_quad  out  SEQ_W  merged quad (registered)
output_ready  in  1  downstream ready
blocks_in_flight  out  clog2(ORDER_DEPTH+1)  order FIFO occupancy

Behaviour:
- Reset (async, rst=1) values:
  - ptr=0, in_block=0, cur=0.
  - Order FIFO empty; blocks_in_flight=0.
  - output_valid=0, output_last=0, output_seq_quad=0.
- Lane selection at block start (in_block=0):
  - sel = first lane with an effective mask bit set, searching from ptr upward and wrapping.
  - Mask is sampled only at block start. Mid-block mask changes do not affect the current block.
- Mid-block (in_block=1): sel = cur, latched at block start.
- Input path is combinational, zero latency:
  - lane_in_valid[sel] = input_valid & go; all other lanes get 0.
  - input_ready = lane_in_ready[sel] & go.
  - go = in_block | !fifo_full.
- On an accepted first beat (in_block=0):
  - Push sel into the order FIFO.
  - cur<=sel; in_block<=1, unless delim is also set.
- On an accepted beat with delim:
  - in_block<=0.
  - ptr <= (sel==LANE_NUM-1) ? 0 : sel+1.
  - A single-beat block performs both the push and the ptr advance in the same cycle.
- Push requires !fifo_full, even when a pop happens in the same cycle. Simultaneous push and pop leaves the count unchanged.
- Collector, head = order FIFO head lane:
  - load = fifo_nonempty & lane_out_valid[head] & (!output_valid | output_ready).
  - lane_out_ready[head] = fifo_nonempty & (!output_valid | output_ready); all other lanes get 0.
  - On load: output regs <= lane head's quad and last; output_valid<=1.
  - Else if output_ready: output_valid<=0.
  - Latency is 1 cycle, with full throughput of 1 quad/cycle under continuous ready.
- Pop the order FIFO when a loaded quad has lane_out_last=1. The next cycle then selects the new head.
- FIFO empty: every lane_out_ready is 0, and output_valid drains to 0.
- Lanes holding quads that are not at the FIFO head are stalled (ready=0). No quad is ever dropped or reordered.
- Asserting rst mid-operation discards in-flight order state. Lanes are reset by the same rst externally.

Test Plan:
- Mask=4'b1111, 4 blocks of 2 beats each, all ready -> lane_in_valid one-hot sequence 1,1,2,2,4,4,8,8; blocks_in_flight reaches 4; ptr ends at 0.
- Mask=4'b1010, 3 single-beat blocks (delim every beat) -> lanes 1,3,1; each block pushes and advances ptr in one cycle.
- Mask=0 -> every block goes to lane 0.
- Mask changed from 4'b1111 to 4'b0001 mid-block on lane 2 -> rest of that block stays on lane 2; next block goes to lane 0.
- ORDER_DEPTH=8, outputs stalled, 9 blocks offered -> input_ready=0 at the 9th block's first beat; it is accepted the cycle after one pop.
- Lanes return quads out of order (lane 1 finishes before lane 0; order 0,1, each block 3 quads, last on the 3rd) -> output is lane 0's 3 quads then lane 1's; output_last on outputs 3 and 6.
- Random output_ready backpressure -> no loss or duplication, and quad order is identical to a reference model.
